// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter slice.
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int N_REQ_DEF       = 3;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 4096;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester streams, UART TX handshake and arbiter status grouped as one bundle.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_last_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic                    tx_valid_o;
    logic [DATA_W-1:0]       tx_data_o;
    logic                    tx_ready_i;
    logic [N_REQ-1:0]        grant_o;
    logic                    busy_o;
    logic                    timeout_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
        output req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_ready_i,
        input  req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after the pointer, wrapping modulo N_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int cand_s;

    // Scan ptr, ptr+1, ... and keep the first set requester.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand_s = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = (int'(ptr_i) + i) % N_REQ;
            if (!any_o && req_i[cand_s]) begin
                any_o         = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = IDX_W'(cand_s);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART TX, with a stall watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   pick_gnt_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               locked_s;
    logic               owner_valid_s;
    logic               owner_last_s;
    logic               beat_s;
    logic [DATA_W-1:0]  tx_data_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic [IDX_W-1:0]   rr_next_s;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i (bus.req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt_s),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    assign locked_s      = (state_q == LOCKED);
    assign owner_valid_s = locked_s && bus.req_valid_i[gidx_q];
    assign owner_last_s  = bus.req_last_i[gidx_q];
    assign beat_s        = owner_valid_s && bus.tx_ready_i;
    assign rr_next_s     = (gidx_q == IDX_LAST) ? IDX_W'(0) : gidx_q + IDX_W'(1);

    // Owner passthrough; data is zeroed whenever no byte is offered.
    always_comb begin
        tx_data_s   = '0;
        req_ready_s = '0;
        if (owner_valid_s) begin
            tx_data_s = bus.req_data_i[int'(gidx_q)*DATA_W +: DATA_W];
        end else begin
            tx_data_s = '0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (locked_s && (gidx_q == IDX_W'(k))) begin
                req_ready_s[k] = bus.tx_ready_i;
            end else begin
                req_ready_s[k] = 1'b0;
            end
        end
    end

    // Lock/release FSM with watchdog; every release passes through one IDLE cycle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                wd_cnt_d = '0;
                if (pick_any_s) begin
                    state_d = LOCKED;
                    grant_d = pick_gnt_s;
                    gidx_d  = pick_idx_s;
                end else begin
                    grant_d = '0;
                end
            end
            LOCKED: begin
                if (beat_s) begin
                    wd_cnt_d = '0;
                    if (owner_last_s) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = rr_next_s;
                    end else begin
                        state_d = LOCKED;
                    end
                end else if (!owner_valid_s) begin
                    if (wd_cnt_q == WD_MAX) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        rr_ptr_d  = rr_next_s;
                        wd_cnt_d  = '0;
                        timeout_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + WD_W'(1);
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                wd_cnt_d = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.tx_valid_o  = owner_valid_s;
    assign bus.tx_data_o   = tx_data_s;
    assign bus.req_ready_o = req_ready_s;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = locked_s;
    assign bus.timeout_o   = timeout_q;

endmodule
